// File: rtl/if_fetch_queue.sv
// Instruction prefetch queue between IF and ID: buffers {PC, instruction} pairs
// across ID stalls, flushes on taken branch/jump, and back-pressures the next-PC mux.
module if_fetch_queue #(
   parameter int RegWidth = 16,
   parameter int Depth    = 4,
   parameter int PtrWidth = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                Flush,
   input  logic                Push_Valid,
   input  logic [RegWidth-1:0] Push_PC,
   input  logic [RegWidth-1:0] Push_Instr,
   output logic                Fetch_Stall,
   input  logic                Pop_Ready,
   output logic                Out_Valid,
   output logic [RegWidth-1:0] Out_PC,
   output logic [RegWidth-1:0] Out_Instr,
   output logic [PtrWidth:0]   Count
);

   // Depth is 2**PtrWidth, so "full" is exactly the MSB-only count value.
   localparam logic [PtrWidth:0]   CNT_FULL = {1'b1, {PtrWidth{1'b0}}};
   localparam logic [PtrWidth:0]   CNT_ONE  = {{PtrWidth{1'b0}}, 1'b1};
   localparam logic [PtrWidth-1:0] PTR_ONE  = {{(PtrWidth-1){1'b0}}, 1'b1};

   logic [RegWidth-1:0] pc_mem_q    [Depth];
   logic [RegWidth-1:0] instr_mem_q [Depth];

   logic [PtrWidth-1:0] wp_q, wp_d;
   logic [PtrWidth-1:0] rp_q, rp_d;
   logic [PtrWidth:0]   cnt_q, cnt_d;

   logic full, empty, push_acc, pop_acc;

   assign full     = (cnt_q == CNT_FULL);
   assign empty    = (cnt_q == '0);
   assign push_acc = Push_Valid && !full;
   assign pop_acc  = Pop_Ready && !empty;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (Flush) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_acc) wp_d = wp_q + PTR_ONE;
         if (pop_acc)  rp_d = rp_q + PTR_ONE;
         case ({push_acc, pop_acc})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only observed while the queue is non-empty.
   always_ff @(posedge CLK) begin
      if (!RST && !Flush && push_acc) begin
         pc_mem_q[wp_q]    <= Push_PC;
         instr_mem_q[wp_q] <= Push_Instr;
      end
   end

   assign Fetch_Stall = full;
   assign Out_Valid   = !empty;
   assign Count       = cnt_q;
   assign Out_PC      = empty ? '0 : pc_mem_q[rp_q];
   assign Out_Instr   = empty ? '0 : instr_mem_q[rp_q];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a queue-based reference model predicts the
// output bundle after every edge; a monitor compares it against the DUT.
module tb_if_fetch_queue;

   localparam int RW    = 16;
   localparam int DEPTH = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          Flush = 1'b0;
   logic          Push_Valid = 1'b0;
   logic [RW-1:0] Push_PC = '0;
   logic [RW-1:0] Push_Instr = '0;
   logic          Fetch_Stall;
   logic          Pop_Ready = 1'b0;
   logic          Out_Valid;
   logic [RW-1:0] Out_PC;
   logic [RW-1:0] Out_Instr;
   logic [2:0]    Count;

   if_fetch_queue #(.RegWidth(RW), .Depth(DEPTH), .PtrWidth(2)) dut (
      .CLK(CLK), .RST(RST), .Flush(Flush),
      .Push_Valid(Push_Valid), .Push_PC(Push_PC), .Push_Instr(Push_Instr),
      .Fetch_Stall(Fetch_Stall), .Pop_Ready(Pop_Ready),
      .Out_Valid(Out_Valid), .Out_PC(Out_PC), .Out_Instr(Out_Instr),
      .Count(Count)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [RW-1:0] pc;
      logic [RW-1:0] instr;
   } entry_t;

   typedef struct packed {
      logic          valid;
      logic [RW-1:0] pc;
      logic [RW-1:0] instr;
      logic [2:0]    cnt;
      logic          stall;
   } exp_t;

   entry_t ref_q[$];
   exp_t   exp_q[$];
   bit     started = 1'b0;
   int     n_checks = 0;
   int     n_fail = 0;

   // Reference model: the queue contents themselves, updated once per edge.
   always @(posedge CLK) begin
      exp_t e;
      bit   do_push, do_pop;
      if (RST) started = 1'b1;
      if (RST || Flush) begin
         ref_q.delete();
      end else begin
         do_push = Push_Valid && (ref_q.size() < DEPTH);
         do_pop  = Pop_Ready && (ref_q.size() > 0);
         if (do_pop) void'(ref_q.pop_front());
         if (do_push) ref_q.push_back('{pc: Push_PC, instr: Push_Instr});
      end
      if (started) begin
         e.valid = ref_q.size() > 0;
         e.pc    = (ref_q.size() > 0) ? ref_q[0].pc : '0;
         e.instr = (ref_q.size() > 0) ? ref_q[0].instr : '0;
         e.cnt   = 3'(ref_q.size());
         e.stall = ref_q.size() == DEPTH;
         exp_q.push_back(e);
      end
   end

   task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
      end
   endtask

   always @(posedge CLK) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("out_valid", RW'(Out_Valid), RW'(e.valid));
         chk("count", RW'(Count), RW'(e.cnt));
         chk("fetch_stall", RW'(Fetch_Stall), RW'(e.stall));
         chk("out_pc", Out_PC, e.pc);
         chk("out_instr", Out_Instr, e.instr);
      end
   end

   // One clock of stimulus; returns #2 after the edge, when outputs are settled.
   task automatic cyc(input bit rst, input bit fl, input bit pv, input int pc, input bit pr);
      RST        = rst;
      Flush      = fl;
      Push_Valid = pv;
      Push_PC    = RW'(pc);
      Push_Instr = RW'(16'h1000 + pc);
      Pop_Ready  = pr;
      @(posedge CLK);
      #2;
   endtask

   initial begin
      // Reset
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("rst_valid", RW'(Out_Valid), '0);
      chk("rst_count", RW'(Count), '0);
      chk("rst_stall", RW'(Fetch_Stall), '0);
      chk("rst_pc", Out_PC, '0);

      // Ordered fill, rejected 5th push, drain
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, i, 0);
      chk("fill_count", RW'(Count), RW'(4));
      chk("fill_stall", RW'(Fetch_Stall), RW'(1));
      cyc(0, 0, 1, 4, 0);
      chk("full_push_ignored", RW'(Count), RW'(4));
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc", Out_PC, RW'(i));
         cyc(0, 0, 0, 0, 1);
      end
      chk("drain_empty", RW'(Out_Valid), '0);

      // Wrap-around
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 10 + i, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 59 + i, 0);
      chk("wrap_count", RW'(Count), RW'(3));
      for (int i = 0; i < 3; i++) begin
         chk("wrap_instr", Out_Instr, RW'(16'h103B + i));
         cyc(0, 0, 0, 0, 1);
      end

      // Simultaneous push and pop at Count=2, then from empty
      cyc(0, 0, 1, 100, 0);
      cyc(0, 0, 1, 101, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 1, 102 + i, 1);
         chk("sim_count", RW'(Count), RW'(2));
         chk("sim_pc", Out_PC, RW'(101 + i));
      end
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 200, 1);
      chk("empty_pushpop_count", RW'(Count), RW'(1));
      cyc(0, 0, 0, 0, 1);

      // Flush with same-cycle push
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 90 + i, 0);
      cyc(0, 1, 1, 93, 0);
      chk("flush_count", RW'(Count), '0);
      chk("flush_valid", RW'(Out_Valid), '0);
      cyc(0, 0, 1, 93, 0);
      chk("post_flush_pc", Out_PC, RW'(93));
      cyc(0, 0, 0, 0, 1);

      // Reset mid-operation while full
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 300 + i, 0);
      chk("pre_rst_stall", RW'(Fetch_Stall), RW'(1));
      cyc(1, 0, 1, 400, 1);
      chk("mid_rst_count", RW'(Count), '0);
      chk("mid_rst_stall", RW'(Fetch_Stall), '0);
      chk("mid_rst_instr", Out_Instr, '0);

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 500; i++) begin
         cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
             ($urandom_range(0, 9) < 7), int'($urandom_range(0, 65535)),
             ($urandom_range(0, 1) == 1));
      end

      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("scoreboard_drained", RW'(exp_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
